// File: rtl/sample_iterator_if.sv
// Bundle between bbox, the sample iterator and the sample test stage.
// The master modport is the iterator's view and the slave modport is the environment's view.
// When ITER_PERF_CNT_EN is defined, the bundle also carries two 32-bit performance counters.
interface sample_iterator_if #(
  parameter int SIGFIG  = 24,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
);
  // Upstream side (from bbox)
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                   validTri_R13H;
  logic                                   halt_RnnnnL;
  logic [3:0]                             subSample_RnnnnU;

  // Downstream side (to the sample test)
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_R14S;
  logic [SAMPLES-1:0]                     validSamp_R14H;

`ifdef ITER_PERF_CNT_EN
  logic [31:0] triCnt_RnnnnU;
  logic [31:0] sampCnt_RnnnnU;

  modport master (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H,
    output triCnt_RnnnnU, sampCnt_RnnnnU
  );

  modport slave (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H,
    input  triCnt_RnnnnU, sampCnt_RnnnnU
  );
`else
  modport master (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    output halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
    input  halt_RnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
`endif
endinterface

// File: rtl/sample_iterator.sv
// Sample test iterator. It accepts one triangle and its bounding box, then walks the box in
// raster order on the subsample grid and emits SAMPLES positions per cycle. Each position has a
// per-lane valid. The first group leaves on the same edge that accepts the triangle.
// Optional feature: define ITER_PERF_CNT_EN to add the triangle and sample counters.
module sample_iterator #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  sample_iterator_if.master bus
);

  typedef enum logic [0:0] {
    StWait = 1'b0,
    StTest = 1'b1
  } state_e;

  typedef logic signed [SIGFIG-1:0] coord_t;

  state_e r_state, w_state_d;

  // Captured box (already snapped to the grid) and the raster cursor
  coord_t r_ll_x, r_ur_x, r_ur_y;
  coord_t r_cur_x, r_cur_y;

  // Registered R14 outputs
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] r_tri;
  logic [COLORS-1:0][SIGFIG-1:0]          r_color;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    r_sample;
  logic [SAMPLES-1:0]                     r_valid;

  coord_t w_step, w_mask;
  coord_t w_in_ll_x, w_in_ll_y, w_in_ur_x, w_in_ur_y;
  coord_t w_ll_x, w_ur_x, w_ur_y, w_gx, w_gy;
  coord_t w_off, w_lane_x, w_next_x, w_next_y;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0] w_sample;
  logic [SAMPLES-1:0]                  w_valid;
  logic w_accept, w_emit, w_degen, w_row_end, w_last;

  // Decode the one-hot subsample config into the grid step and snap the incoming box to it
  always_comb begin
    w_step = coord_t'(1) << RADIX;
    unique case (bus.subSample_RnnnnU)
      4'b0001: w_step = coord_t'(1) << (RADIX - 3);
      4'b0010: w_step = coord_t'(1) << (RADIX - 2);
      4'b0100: w_step = coord_t'(1) << (RADIX - 1);
      4'b1000: w_step = coord_t'(1) << RADIX;
      default: w_step = coord_t'(1) << RADIX;
    endcase
    w_mask    = ~(w_step - coord_t'(1));
    w_in_ll_x = $signed(bus.box_R13S[0][0]) & w_mask;
    w_in_ll_y = $signed(bus.box_R13S[0][1]) & w_mask;
    w_in_ur_x = $signed(bus.box_R13S[1][0]) & w_mask;
    w_in_ur_y = $signed(bus.box_R13S[1][1]) & w_mask;
  end

  // Build the group to emit this edge, and advance the raster cursor
  always_comb begin
    w_accept = (r_state == StWait) && bus.validTri_R13H;
    w_emit   = w_accept || (r_state == StTest);

    // On accept, the group comes straight from the incoming box and not from the cursor
    if (w_accept) begin
      w_ll_x = w_in_ll_x;
      w_ur_x = w_in_ur_x;
      w_ur_y = w_in_ur_y;
      w_gx   = w_in_ll_x;
      w_gy   = w_in_ll_y;
    end else begin
      w_ll_x = r_ll_x;
      w_ur_x = r_ur_x;
      w_ur_y = r_ur_y;
      w_gx   = r_cur_x;
      w_gy   = r_cur_y;
    end

    // An empty box still produces one all-invalid group and then ends
    w_degen = (w_ll_x > w_ur_x) || (w_gy > w_ur_y);

    w_off    = '0;
    w_lane_x = '0;
    w_sample = '0;
    w_valid  = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      w_lane_x       = w_gx + w_off;
      w_sample[k][0] = w_lane_x;
      w_sample[k][1] = w_gy;
      w_valid[k]     = !w_degen && (w_lane_x <= w_ur_x);
      w_off          = w_off + w_step;
    end

    // Here w_off holds SAMPLES*step, which is the horizontal stride of one group
    w_row_end = (w_gx + w_off) > w_ur_x;
    w_last    = w_degen || (w_row_end && ((w_gy + w_step) > w_ur_y));

    if (w_row_end) begin
      w_next_x = w_ll_x;
      w_next_y = w_gy + w_step;
    end else begin
      w_next_x = w_gx + w_off;
      w_next_y = w_gy;
    end
  end

  // Next-state logic: each emitted group either continues the walk or finishes the triangle
  always_comb begin
    w_state_d = r_state;
    if (w_emit) begin
      w_state_d = w_last ? StWait : StTest;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StWait;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Box capture on accept; the cursor advances on every emitted group
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ll_x  <= '0;
      r_ur_x  <= '0;
      r_ur_y  <= '0;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      if (w_accept) begin
        r_ll_x <= w_in_ll_x;
        r_ur_x <= w_in_ur_x;
        r_ur_y <= w_in_ur_y;
      end
      if (w_emit) begin
        r_cur_x <= w_next_x;
        r_cur_y <= w_next_y;
      end
    end
  end

  // Output group register; when idle, lane valids drop and the payload holds its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri    <= '0;
      r_color  <= '0;
      r_sample <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= w_emit ? w_valid : '0;
      if (w_emit) begin
        r_sample <= w_sample;
      end
      if (w_accept) begin
        r_tri   <= bus.tri_R13S;
        r_color <= bus.color_R13U;
      end
    end
  end

  assign bus.halt_RnnnnL    = (r_state == StWait);
  assign bus.tri_R14S       = r_tri;
  assign bus.color_R14U     = r_color;
  assign bus.sample_R14S    = r_sample;
  assign bus.validSamp_R14H = r_valid;

`ifdef ITER_PERF_CNT_EN
  logic [31:0] r_tri_cnt, r_samp_cnt, w_pop;

  // Count the valid lanes currently presented
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      w_pop = w_pop + 32'(r_valid[k]);
    end
  end

  // Free-running counters that wrap modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tri_cnt  <= '0;
      r_samp_cnt <= '0;
    end else begin
      r_tri_cnt  <= r_tri_cnt + 32'(w_accept);
      r_samp_cnt <= r_samp_cnt + w_pop;
    end
  end

  assign bus.triCnt_RnnnnU  = r_tri_cnt;
  assign bus.sampCnt_RnnnnU = r_samp_cnt;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator. A reference model expands each triangle's box into
// the expected group sequence with plain loops. Streams of triangles are presented back-to-back,
// and every output cycle is compared with the model.
module tb_sample_iterator;
  localparam int SIGFIG  = 24;
  localparam int RADIX   = 10;
  localparam int VERTS   = 3;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 2;

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
  typedef logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    samp_t;

  typedef struct {
    tri_t t;
    col_t c;
    int   llx, lly, urx, ury;
  } trin_t;

  typedef struct packed {
    logic [SAMPLES-1:0]             v;
    logic [SAMPLES-1:0][SIGFIG-1:0] x;
    logic [SIGFIG-1:0]              y;
    logic [7:0]                     id;
    logic                           last;
  } grp_t;

  logic clk = 1'b0;
  logic rst;

  sample_iterator_if #(
    .SIGFIG (SIGFIG),
    .VERTS  (VERTS),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .SAMPLES(SAMPLES)
  ) bus ();

  sample_iterator #(
    .SIGFIG (SIGFIG),
    .RADIX  (RADIX),
    .VERTS  (VERTS),
    .AXIS   (AXIS),
    .COLORS (COLORS),
    .SAMPLES(SAMPLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    step;
  trin_t tq[$];
  grp_t  eq[$];

  function automatic tri_t rand_tri();
    tri_t t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) t[v][a] = SIGFIG'($urandom);
    return t;
  endfunction

  function automatic col_t rand_col();
    col_t c;
    for (int i = 0; i < COLORS; i++) c[i] = SIGFIG'($urandom);
    return c;
  endfunction

  function automatic trin_t make_tri(input int llx, input int lly, input int urx, input int ury);
    trin_t r;
    r.t = rand_tri();
    r.c = rand_col();
    r.llx = llx; r.lly = lly; r.urx = urx; r.ury = ury;
    return r;
  endfunction

  task automatic set_step(input int s);
    step = s;
    case (s)
      128:     bus.subSample_RnnnnU = 4'b0001;
      256:     bus.subSample_RnnnnU = 4'b0010;
      512:     bus.subSample_RnnnnU = 4'b0100;
      default: bus.subSample_RnnnnU = 4'b1000;
    endcase
  endtask

  // Reference model: expand one triangle into its raster-ordered groups (non-negative coords)
  function automatic void model_tri(input int id);
    int   llx, lly, urx, ury;
    grp_t g;
    llx = (tq[id].llx / step) * step;
    lly = (tq[id].lly / step) * step;
    urx = (tq[id].urx / step) * step;
    ury = (tq[id].ury / step) * step;
    if (llx > urx || lly > ury) begin
      g = '0;
      for (int k = 0; k < SAMPLES; k++) g.x[k] = SIGFIG'(llx + k * step);
      g.y = SIGFIG'(lly);
      g.id = 8'(id);
      g.last = 1'b1;
      eq.push_back(g);
    end else begin
      for (int y = lly; y <= ury; y += step) begin
        for (int x = llx; x <= urx; x += SAMPLES * step) begin
          g = '0;
          for (int k = 0; k < SAMPLES; k++) begin
            g.x[k] = SIGFIG'(x + k * step);
            g.v[k] = (x + k * step <= urx);
          end
          g.y = SIGFIG'(y);
          g.id = 8'(id);
          g.last = (y + step > ury) && (x + SAMPLES * step > urx);
          eq.push_back(g);
        end
      end
    end
  endfunction

  task automatic present(input int i);
    bus.tri_R13S       = tq[i].t;
    bus.color_R13U     = tq[i].c;
    bus.box_R13S[0][0] = SIGFIG'(tq[i].llx);
    bus.box_R13S[0][1] = SIGFIG'(tq[i].lly);
    bus.box_R13S[1][0] = SIGFIG'(tq[i].urx);
    bus.box_R13S[1][1] = SIGFIG'(tq[i].ury);
    bus.validTri_R13H  = 1'b1;
  endtask

  // Random upstream content while the iterator is busy; the DUT must ignore it
  task automatic drive_junk();
    bus.tri_R13S      = rand_tri();
    bus.color_R13U    = rand_col();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) bus.box_R13S[i][j] = SIGFIG'($urandom_range(0, 4095));
    bus.validTri_R13H = 1'($urandom);
  endtask

  // Present every triangle in tq back-to-back and compare each output cycle with the model
  task automatic run_stream(input string name, output int halt_low, output int valid_cycles);
    grp_t  g;
    samp_t es;
    samp_t last_es;
    tri_t  last_t;
    eq.delete();
    for (int i = 0; i < tq.size(); i++) model_tri(i);
    halt_low = 0;
    valid_cycles = 0;
    last_es = '0;
    last_t = '0;
    @(posedge clk); #1;
    present(0);
    for (int n = 0; n < eq.size(); n++) begin
      @(posedge clk); #1;
      g = eq[n];
      for (int k = 0; k < SAMPLES; k++) begin
        es[k][0] = g.x[k];
        es[k][1] = g.y;
      end
      if (bus.halt_RnnnnL === 1'b0) halt_low++;
      if (bus.validSamp_R14H !== '0) valid_cycles++;
      checks++;
      if (bus.validSamp_R14H !== g.v) begin
        errors++;
        $display("FAIL %s valid grp %0d: got %b want %b", name, n, bus.validSamp_R14H, g.v);
      end
      checks++;
      if (bus.sample_R14S !== es) begin
        errors++;
        $display("FAIL %s sample grp %0d: got %h want %h", name, n, bus.sample_R14S, es);
      end
      checks++;
      if (bus.tri_R14S !== tq[g.id].t || bus.color_R14U !== tq[g.id].c) begin
        errors++;
        $display("FAIL %s tri/color grp %0d: got %h/%h want %h/%h", name, n,
                 bus.tri_R14S, bus.color_R14U, tq[g.id].t, tq[g.id].c);
      end
      checks++;
      if (bus.halt_RnnnnL !== g.last) begin
        errors++;
        $display("FAIL %s halt grp %0d: got %b want %b", name, n, bus.halt_RnnnnL, g.last);
      end
      last_es = es;
      last_t = tq[g.id].t;
      if (g.last) begin
        if (int'(g.id) + 1 < tq.size()) present(int'(g.id) + 1);
        else bus.validTri_R13H = 1'b0;
      end else begin
        drive_junk();
      end
    end
    // Idle: valid lanes drop and the payload holds its last value
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (bus.validSamp_R14H !== '0 || bus.halt_RnnnnL !== 1'b1) begin
        errors++;
        $display("FAIL %s idle valid/halt: got %b/%b want 0/1", name, bus.validSamp_R14H,
                 bus.halt_RnnnnL);
      end
      checks++;
      if (bus.sample_R14S !== last_es || bus.tri_R14S !== last_t) begin
        errors++;
        $display("FAIL %s idle hold: got %h/%h want %h/%h", name, bus.sample_R14S,
                 bus.tri_R14S, last_es, last_t);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.halt_RnnnnL !== 1'b1 || bus.validSamp_R14H !== '0) begin
      errors++;
      $display("FAIL reset halt/valid: got %b/%b want 1/0", bus.halt_RnnnnL, bus.validSamp_R14H);
    end
    checks++;
    if (bus.sample_R14S !== '0 || bus.tri_R14S !== '0 || bus.color_R14U !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %h/%h/%h want 0", bus.sample_R14S, bus.tri_R14S,
               bus.color_R14U);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.halt_RnnnnL !== 1'b1 || bus.validSamp_R14H !== '0) begin
      errors++;
      $display("FAIL reset idle: got %b/%b want 1/0", bus.halt_RnnnnL, bus.validSamp_R14H);
    end
  endtask

  task automatic test_grid();
    int hl, vc;
    set_step(1024);
    tq.delete();
    tq.push_back(make_tri(0, 0, 3072, 1024));
    run_stream("grid", hl, vc);
    checks++;
    if (hl !== 3) begin
      errors++;
      $display("FAIL grid halt_low_cycles: got %0d want 3", hl);
    end
    checks++;
    if (vc !== 4) begin
      errors++;
      $display("FAIL grid valid_cycles: got %0d want 4", vc);
    end
  endtask

  task automatic test_row_partial();
    int hl, vc;
    set_step(1024);
    tq.delete();
    tq.push_back(make_tri(0, 0, 2048, 0));
    run_stream("row_partial", hl, vc);
  endtask

  task automatic test_single();
    int hl, vc;
    set_step(512);
    tq.delete();
    tq.push_back(make_tri(512, 512, 512, 512));
    run_stream("single", hl, vc);
    checks++;
    if (hl !== 0) begin
      errors++;
      $display("FAIL single halt_low_cycles: got %0d want 0", hl);
    end
  endtask

  task automatic test_degenerate();
    int hl, vc;
    set_step(1024);
    tq.delete();
    tq.push_back(make_tri(2048, 0, 1024, 0));
    run_stream("degenerate", hl, vc);
    checks++;
    if (hl !== 0 || vc !== 0) begin
      errors++;
      $display("FAIL degenerate halt_low/valid_cycles: got %0d/%0d want 0/0", hl, vc);
    end
  endtask

  task automatic test_back_to_back();
    int hl, vc;
    set_step(1024);
    tq.delete();
    tq.push_back(make_tri(0, 0, 1024, 1024));
    tq.push_back(make_tri(4096, 2048, 5120, 3072));
    run_stream("back_to_back", hl, vc);
    checks++;
    if (vc !== 4) begin
      errors++;
      $display("FAIL back_to_back valid_cycles: got %0d want 4", vc);
    end
  endtask

  task automatic test_reset_mid();
    int hl, vc;
    set_step(1024);
    tq.delete();
    tq.push_back(make_tri(0, 0, 3072, 1024));
    @(posedge clk); #1;
    present(0);
    @(posedge clk); #1;
    bus.validTri_R13H = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.validSamp_R14H !== '0 || bus.halt_RnnnnL !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid async: got valid %b halt %b want 0/1", bus.validSamp_R14H,
               bus.halt_RnnnnL);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.validSamp_R14H !== '0 || bus.halt_RnnnnL !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid after: got valid %b halt %b want 0/1", bus.validSamp_R14H,
               bus.halt_RnnnnL);
    end
    tq.delete();
    tq.push_back(make_tri(1024, 1024, 2048, 2048));
    run_stream("post_reset", hl, vc);
  endtask

  task automatic test_random();
    int hl, vc, s, llx, lly, urx, ury;
    for (int r = 0; r < 4; r++) begin
      s = 128 << $urandom_range(0, 3);
      set_step(s);
      tq.delete();
      for (int i = 0; i < 12; i++) begin
        llx = $urandom_range(2048, 16000);
        lly = $urandom_range(0, 16000);
        urx = llx + $urandom_range(0, 5 * s);
        ury = lly + $urandom_range(0, 3 * s);
        if ($urandom_range(0, 9) == 0) urx = llx - s - 1;
        tq.push_back(make_tri(llx, lly, urx, ury));
      end
      run_stream("random", hl, vc);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.validTri_R13H = 1'b0;
    bus.tri_R13S = '0;
    bus.color_R13U = '0;
    bus.box_R13S = '0;
    set_step(1024);
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_grid();
    test_row_partial();
    test_single();
    test_degenerate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
